score_display: RTL and testbench

- Reader side of the 8-bit game score produced by the collision score counter.
- Samples the binary score and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed, common-anode 4-digit seven-segment display on the board.
- Sits between the score counter and the top-level display pins.

---
 rtl/score_display_pkg.sv | 33 +++
 rtl/score_display_seg7_decode.sv | 28 ++
 rtl/score_display.sv | 164 ++++++++++++++++
 tb/tb_score_display.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared constants for the score display: converter state encoding,
// active-low seven-segment patterns {g,f,e,d,c,b,a} and the all-off anode
// value, plus the double-dabble nibble correction used by the converter.
package score_display_pkg;

   // Converter FSM encoding (kept as plain constants for legacy tools)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_LATCH   = 2'd2;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // All anodes released (active-low, so every digit dark)
   localparam logic [3:0] AN_OFF = 4'b1111;

   // Double-dabble correction: a nibble of 5 or more would overflow past 9
   // after the next shift, so pre-add 3 to make it carry into the next digit.
   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      bcd_adjust = (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes 10-15 never carry a meaningful digit and are shown dark.
module seg7_decode
   import score_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Lookup of the segment pattern for one decimal digit
   always_comb begin
      seg = SEG_OFF;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// Score display: watches the 8-bit game score, converts each new value to
// three BCD digits with a sequential shift-add-3 engine, and scans them onto
// a common-anode 4-digit seven-segment display (rightmost three digits used).
module score_display
   import score_display_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_LEADING = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] score,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       busy
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

   // Converter state
   logic [1:0]  state;
   logic [2:0]  iter;
   logic [7:0]  shift_reg;
   logic [7:0]  last_score;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;

   // Displayed digits
   logic [3:0]  hund;
   logic [3:0]  tens;
   logic [3:0]  ones;

   // Scan state
   logic [PW-1:0] prescaler;
   logic [1:0]    slot;
   logic [3:0]    digit_sel;
   logic [6:0]    digit_seg;
   logic          blank_hund;
   logic          blank_tens;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;

   // Decimal point is never used on this display
   assign dp = 1'b1;

   // Add-3 correction of every working nibble ahead of the next shift
   always_comb begin
      bcd_adj = {bcd_adjust(bcd[11:8]), bcd_adjust(bcd[7:4]), bcd_adjust(bcd[3:0])};
   end

   // Converter FSM: capture a changed score, run 8 shift steps, latch digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         iter       <= 3'd0;
         shift_reg  <= 8'd0;
         last_score <= 8'd0;
         bcd        <= 12'd0;
         hund       <= 4'd0;
         tens       <= 4'd0;
         ones       <= 4'd0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // The score is compared unregistered; the producer shares clk
               if (score != last_score) begin
                  shift_reg  <= score;
                  last_score <= score;
                  bcd        <= 12'd0;
                  iter       <= 3'd0;
                  busy       <= 1'b1;
                  state      <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               {bcd, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
               iter             <= iter + 3'd1;
               if (iter == 3'd7) begin
                  state <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               hund  <= bcd[11:8];
               tens  <= bcd[7:4];
               ones  <= bcd[3:0];
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Refresh prescaler and digit slot counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
         slot      <= 2'd0;
      end else if (prescaler == PRE_MAX) begin
         prescaler <= '0;
         slot      <= slot + 2'd1;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Digit selection and leading-zero blanking for the current slot
   always_comb begin
      blank_hund = (BLANK_LEADING != 0) && (hund == 4'd0);
      blank_tens = blank_hund && (tens == 4'd0);
      digit_sel  = ones;
      an_next    = AN_OFF;
      seg_next   = SEG_OFF;
      case (slot)
         2'd0: begin
            digit_sel = ones;
            an_next   = 4'b1110;
            seg_next  = digit_seg;
         end
         2'd1: begin
            digit_sel = tens;
            if (!blank_tens) begin
               an_next  = 4'b1101;
               seg_next = digit_seg;
            end
         end
         2'd2: begin
            digit_sel = hund;
            if (!blank_hund) begin
               an_next  = 4'b1011;
               seg_next = digit_seg;
            end
         end
         default: begin
            digit_sel = ones;
            an_next   = AN_OFF;
            seg_next  = SEG_OFF;
         end
      endcase
   end

   seg7_decode u_decode (
      .digit (digit_sel),
      .seg   (digit_seg)
   );

   // Registered display drive, one cycle behind the slot counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
      end else begin
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: two instances (leading-zero blanking on and off)
// share the score input and are compared every cycle against a reference
// model built from decimal arithmetic and a conversion-latency schedule.
module tb_score_display;

   localparam int DIV = 4;

   logic       clk;
   logic       rst;
   logic [7:0] score;
   logic [3:0] an_b, an_nb;
   logic [6:0] seg_b, seg_nb;
   logic       dp_b, dp_nb;
   logic       busy_b, busy_nb;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [6:0] seg_tab [0:9];
   int   cyc;
   int   disp_val;
   int   last_m;
   int   conv_val;
   int   rem;
   logic [3:0] exp_an_b, exp_an_nb;
   logic [6:0] exp_seg_b, exp_seg_nb;
   logic       exp_busy;

   score_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .score (score),
      .an    (an_b),
      .seg   (seg_b),
      .dp    (dp_b),
      .busy  (busy_b)
   );

   score_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) u_dut_nb (
      .clk   (clk),
      .rst   (rst),
      .score (score),
      .an    (an_nb),
      .seg   (seg_nb),
      .dp    (dp_nb),
      .busy  (busy_nb)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // What the display should show in a slot for a given decimal value
   function automatic void expected_view(input int slot, input int value, input bit blank,
                                         output logic [3:0] a, output logic [6:0] s);
      int h, t, o;
      h = value / 100;
      t = (value / 10) % 10;
      o = value % 10;
      a = 4'b1111;
      s = 7'b1111111;
      if (slot == 0) begin
         a = 4'b1110; s = seg_tab[o];
      end else if (slot == 1) begin
         if (!(blank && h == 0 && t == 0)) begin a = 4'b1101; s = seg_tab[t]; end
      end else if (slot == 2) begin
         if (!(blank && h == 0)) begin a = 4'b1011; s = seg_tab[h]; end
      end
   endfunction

   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
   end

   // Reference model: a changed score seen while idle is shown 10 edges
   // later; busy spans the 9 cycles in between; slot = (cycles/DIV) mod 4.
   always @(posedge clk) begin
      if (rst) begin
         cyc = 0; disp_val = 0; last_m = 0; conv_val = 0; rem = 0;
         exp_an_b = 4'b1111; exp_an_nb = 4'b1111;
         exp_seg_b = 7'b1111111; exp_seg_nb = 7'b1111111;
         exp_busy = 1'b0;
      end else begin
         expected_view((cyc / DIV) % 4, disp_val, 1'b1, exp_an_b, exp_seg_b);
         expected_view((cyc / DIV) % 4, disp_val, 1'b0, exp_an_nb, exp_seg_nb);
         cyc++;
         if (rem > 0) begin
            rem--;
            if (rem == 0) disp_val = conv_val;
         end else if (int'(score) != last_m) begin
            last_m   = int'(score);
            conv_val = int'(score);
            rem      = 9;
         end
         exp_busy = (rem > 0);
      end
   end

   // Per-cycle comparison, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         check_val("an_rst", an_b, 4'b1111);
         check_val("seg_rst", seg_b, 7'b1111111);
         check_val("busy_rst", busy_b, 1'b0);
         check_val("an_nb_rst", an_nb, 4'b1111);
      end else begin
         check_val("an", an_b, exp_an_b);
         check_val("seg", seg_b, exp_seg_b);
         check_val("busy", busy_b, exp_busy);
         check_val("an_nb", an_nb, exp_an_nb);
         check_val("seg_nb", seg_nb, exp_seg_nb);
         check_val("busy_nb", busy_nb, exp_busy);
      end
      check_val("dp", dp_b, 1'b1);
      check_val("dp_nb", dp_nb, 1'b1);
   end

   task automatic hold(input int v, input int n);
      score = v[7:0];
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      score = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle "0", then single conversions and boundaries
      hold(0, 20);
      hold(173, 40);
      hold(255, 40);
      hold(9, 40);
      // Change during conversion
      hold(50, 4);
      hold(200, 60);

      // Asynchronous reset in the middle of a conversion
      score = 8'd42;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      check_val("busy_pre_rst", busy_b, 1'b1);
      rst = 1'b1;
      #1;
      check_val("an_async_rst", an_b, 4'b1111);
      check_val("seg_async_rst", seg_b, 7'b1111111);
      check_val("busy_async_rst", busy_b, 1'b0);
      check_val("busy_nb_async_rst", busy_nb, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      hold(42, 40);

      // Randomised score stream, including changes mid-conversion
      for (int i = 0; i < 250; i++) begin
         int v;
         if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 12);
         else v = $urandom_range(0, 255);
         hold(v, $urandom_range(1, 24));
      end
      hold(int'($urandom_range(0, 255)), 40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
